beta_if_stage: RTL and testbench

//  Instruction fetch stage: first pipe stage, upstream end of the decode-stage instruction interface.

---
 rtl/beta_if_stage.sv | 120 ++++++++++++
 tb/tb_beta_if_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_if_stage.sv
// Instruction fetch stage: owns the PC, drives the req/gnt/rvalid instruction
// memory handshake and hands fetched instructions to decode.
module beta_if_stage #(
  parameter int unsigned              DataWidth = 32,
  parameter logic [DataWidth-1:0]     BootAddr  = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 if_imem_req_o,
  output logic [DataWidth-1:0] if_imem_addr_o,
  input  logic                 if_imem_gnt_i,
  input  logic                 if_imem_rvalid_i,
  input  logic [DataWidth-1:0] if_imem_rdata_i,
  input  logic                 if_stall_i,
  input  logic                 if_jump_en_i,
  input  logic [DataWidth-1:0] if_jump_target_i,
  output logic [DataWidth-1:0] if_instr_o,
  output logic                 if_new_instr_o,
  output logic [DataWidth-1:0] if_pc_o,
  output logic [DataWidth-1:0] if_next_pc_o,
  output logic                 if_stage_busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [DataWidth-1:0] PcStep = DataWidth'(4);
  localparam logic [DataWidth-1:0] Nop    = DataWidth'(32'h0000_0013);

  state_e               state_q, state_d;
  logic [DataWidth-1:0] pc_q;
  logic                 pend_jmp_q;
  logic [DataWidth-1:0] pend_tgt_q;
  logic [DataWidth-1:0] instr_q;
  logic [DataWidth-1:0] out_pc_q;
  logic [DataWidth-1:0] out_next_pc_q;
  logic                 new_instr_q;

  logic [DataWidth-1:0] jump_tgt;
  logic                 rsp_done;
  logic                 discard;
  logic                 deliver;

  always_comb begin
    jump_tgt = {if_jump_target_i[DataWidth-1:2], 2'b00};
    rsp_done = (state_q == WAIT) && if_imem_rvalid_i;
    // A redirect seen at any point during the transaction, including the
    // completing cycle itself, makes the returned word stale.
    discard  = rsp_done && (pend_jmp_q || if_jump_en_i);
    deliver  = rsp_done && !discard;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = if_stall_i ? HOLD : REQ;
      REQ:  if (if_imem_gnt_i) state_d = WAIT;
      WAIT: if (if_imem_rvalid_i) state_d = if_stall_i ? HOLD : REQ;
      HOLD: if (!if_stall_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= BootAddr;
      pend_jmp_q    <= 1'b0;
      pend_tgt_q    <= '0;
      instr_q       <= Nop;
      out_pc_q      <= BootAddr;
      out_next_pc_q <= BootAddr + PcStep;
      new_instr_q   <= 1'b0;
    end else begin
      new_instr_q <= 1'b0;
      if (deliver) begin
        instr_q       <= if_imem_rdata_i;
        out_pc_q      <= pc_q;
        out_next_pc_q <= pc_q + PcStep;
        pc_q          <= pc_q + PcStep;
        new_instr_q   <= 1'b1;
      end
      if (discard) begin
        pc_q       <= if_jump_en_i ? jump_tgt : pend_tgt_q;
        pend_jmp_q <= 1'b0;
      end else if (if_jump_en_i) begin
        // Outside a transaction the PC can move at once; inside one it must
        // wait until the outstanding response has been retired.
        if ((state_q == IDLE) || (state_q == HOLD)) begin
          pc_q <= jump_tgt;
        end else begin
          pend_jmp_q <= 1'b1;
          pend_tgt_q <= jump_tgt;
        end
      end
    end
  end

  always_comb begin
    if_imem_req_o   = (state_q == REQ);
    if_imem_addr_o  = pc_q;
    if_stage_busy_o = (state_q == REQ) || (state_q == WAIT);
    if_instr_o      = instr_q;
    if_new_instr_o  = new_instr_q;
    if_pc_o         = out_pc_q;
    if_next_pc_o    = out_next_pc_q;
  end

endmodule

// File: tb/tb_beta_if_stage.sv
// Directed bench for beta_if_stage: a small instruction memory model, a
// scoreboard of expected deliveries and a monitor that checks every pulse.
module tb_beta_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_imem_req_o;
  logic [31:0] if_imem_addr_o;
  logic        if_imem_gnt_i = 1'b0;
  logic        if_imem_rvalid_i = 1'b0;
  logic [31:0] if_imem_rdata_i = '0;
  logic        if_stall_i = 1'b0;
  logic        if_jump_en_i = 1'b0;
  logic [31:0] if_jump_target_i = '0;
  logic [31:0] if_instr_o;
  logic        if_new_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_next_pc_o;
  logic        if_stage_busy_o;

  beta_if_stage #(
    .DataWidth(32),
    .BootAddr (32'h0000_0000)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .if_imem_req_o   (if_imem_req_o),
    .if_imem_addr_o  (if_imem_addr_o),
    .if_imem_gnt_i   (if_imem_gnt_i),
    .if_imem_rvalid_i(if_imem_rvalid_i),
    .if_imem_rdata_i (if_imem_rdata_i),
    .if_stall_i      (if_stall_i),
    .if_jump_en_i    (if_jump_en_i),
    .if_jump_target_i(if_jump_target_i),
    .if_instr_o      (if_instr_o),
    .if_new_instr_o  (if_new_instr_o),
    .if_pc_o         (if_pc_o),
    .if_next_pc_o    (if_next_pc_o),
    .if_stage_busy_o (if_stage_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gnt_delay = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h00A0_0113;
      32'h8: return 32'h00F0_0193;
      default: return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] npc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.npc   = npc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Memory: grant after gnt_delay request cycles, data one cycle after grant.
  initial begin : memory
    int          wait_cnt;
    bit          rv_pend;
    logic [31:0] rv_addr;
    wait_cnt = 0;
    rv_pend  = 1'b0;
    rv_addr  = '0;
    forever begin
      @(negedge clk_i);
      if_imem_gnt_i    = 1'b0;
      if_imem_rvalid_i = 1'b0;
      if (rv_pend) begin
        if_imem_rvalid_i = 1'b1;
        if_imem_rdata_i  = mem_word(rv_addr);
        rv_pend          = 1'b0;
      end
      if (rst_i !== 1'b0) begin
        wait_cnt = 0;
      end else if (if_imem_req_o) begin
        if (wait_cnt == gnt_delay) begin
          if_imem_gnt_i = 1'b1;
          rv_addr       = if_imem_addr_o;
          rv_pend       = 1'b1;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b0 && if_new_instr_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got instr %h pc %h expected no pulse at %0t",
                   if_instr_o, if_pc_o, $time);
        end else begin
          e = sb.pop_front();
          chk("pulse_instr", if_instr_o, e.instr);
          chk("pulse_pc", if_pc_o, e.pc);
          chk("pulse_next_pc", if_next_pc_o, e.npc);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_i = 1'b1;
    tick();
    tick();
    chk("rst_req", {31'h0, if_imem_req_o}, 32'h0);
    chk("rst_busy", {31'h0, if_stage_busy_o}, 32'h0);
    chk("rst_new", {31'h0, if_new_instr_o}, 32'h0);
    chk("rst_instr", if_instr_o, 32'h0000_0013);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_next_pc", if_next_pc_o, 32'h4);
    chk("rst_addr", if_imem_addr_o, 32'h0);
    rst_i = 1'b0;
    push(32'h0050_0093, 32'h0, 32'h4);

    tick();
    chk("first_req", {31'h0, if_imem_req_o}, 32'h1);
    chk("first_addr", if_imem_addr_o, 32'h0);
    chk("first_busy", {31'h0, if_stage_busy_o}, 32'h1);
    chk("first_instr", if_instr_o, 32'h0000_0013);
    tick();
    chk("wait_req", {31'h0, if_imem_req_o}, 32'h0);
    chk("wait_busy", {31'h0, if_stage_busy_o}, 32'h1);
    tick();
    chk("deliver0_new", {31'h0, if_new_instr_o}, 32'h1);
    chk("addr4_req", {31'h0, if_imem_req_o}, 32'h1);
    chk("addr4", if_imem_addr_o, 32'h4);
    push(32'h00A0_0113, 32'h4, 32'h8);
    if_stall_i = 1'b1;
    tick();
    chk("stall_wait_busy", {31'h0, if_stage_busy_o}, 32'h1);
    chk("stall_gap_new", {31'h0, if_new_instr_o}, 32'h0);
    tick();
    chk("deliver4_new", {31'h0, if_new_instr_o}, 32'h1);
    chk("hold_busy", {31'h0, if_stage_busy_o}, 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("hold_req", {31'h0, if_imem_req_o}, 32'h0);
      if (i < 3) tick();
    end
    if_stall_i = 1'b0;
    gnt_delay  = 3;
    push(32'h00F0_0193, 32'h8, 32'hC);

    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      chk("slow_req", {31'h0, if_imem_req_o}, 32'h1);
      chk("slow_addr", if_imem_addr_o, 32'h8);
      chk("slow_busy", {31'h0, if_stage_busy_o}, 32'h1);
      tick();
    end
    chk("slow_wait_req", {31'h0, if_imem_req_o}, 32'h0);
    chk("slow_wait_busy", {31'h0, if_stage_busy_o}, 32'h1);
    gnt_delay = 0;
    tick();
    chk("addrc", if_imem_addr_o, 32'hC);
    if_jump_en_i     = 1'b1;
    if_jump_target_i = 32'h0000_000B;
    tick();
    if_jump_en_i = 1'b0;
    chk("pend_wait_req", {31'h0, if_imem_req_o}, 32'h0);
    tick();
    chk("pend_discard_new", {31'h0, if_new_instr_o}, 32'h0);
    chk("pend_discard_instr", if_instr_o, 32'h00F0_0193);
    chk("pend_discard_pc", if_pc_o, 32'h8);
    chk("pend_redirect_addr", if_imem_addr_o, 32'h8);
    tick();
    if_jump_en_i     = 1'b1;
    if_jump_target_i = 32'h0000_0103;
    tick();
    if_jump_en_i = 1'b0;
    chk("jump_discard_new", {31'h0, if_new_instr_o}, 32'h0);
    chk("jump_req", {31'h0, if_imem_req_o}, 32'h1);
    chk("jump_addr", if_imem_addr_o, 32'h100);
    push(32'hC0DE_0100, 32'h100, 32'h104);
    tick();
    if_stall_i = 1'b1;
    tick();
    chk("hold2_req", {31'h0, if_imem_req_o}, 32'h0);
    chk("hold2_addr", if_imem_addr_o, 32'h104);
    if_jump_en_i     = 1'b1;
    if_jump_target_i = 32'h0000_0021;
    tick();
    if_jump_en_i = 1'b0;
    if_stall_i   = 1'b0;
    chk("hold_jump_req", {31'h0, if_imem_req_o}, 32'h0);
    chk("hold_jump_addr", if_imem_addr_o, 32'h20);
    tick();
    chk("addr20_req", {31'h0, if_imem_req_o}, 32'h1);
    chk("addr20", if_imem_addr_o, 32'h20);
    tick();
    chk("wait20_busy", {31'h0, if_stage_busy_o}, 32'h1);
    rst_i = 1'b1;
    tick();
    chk("midrst_req", {31'h0, if_imem_req_o}, 32'h0);
    chk("midrst_busy", {31'h0, if_stage_busy_o}, 32'h0);
    chk("midrst_new", {31'h0, if_new_instr_o}, 32'h0);
    chk("midrst_addr", if_imem_addr_o, 32'h0);
    chk("midrst_instr", if_instr_o, 32'h0000_0013);
    rst_i = 1'b0;
    push(32'h0050_0093, 32'h0, 32'h4);
    tick();
    chk("refetch_req", {31'h0, if_imem_req_o}, 32'h1);
    chk("refetch_addr", if_imem_addr_o, 32'h0);
    if_stall_i = 1'b1;
    for (int unsigned i = 0; i < 6; i++) tick();
    chk("sb_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
